pwm_capture: RTL and testbench
==============================

# pwm_capture

Measures the period and high time of an incoming PWM waveform in microseconds, the receive-side counterpart of the `pwm` generator (`period`/`dutty` in µs). Samples an asynchronous `pwm_in` on `clk` and derives an internal 1 µs tick enable from `clk` with no generated clock. Publishes one registered `period`/`dutty` pair per complete input cycle with a one-cycle `valid` strobe. Flags a stuck-high or stuck-low input.

## Interface
- `CLK_FREQ_HZ`, 100_000_000: `clk` frequency. Must be an integer multiple of 1 MHz, ≥ 2 MHz.
- `TIMEOUT_US`, 1_000_000: µs without a qualifying edge before `timeout` asserts.
- `FILTER_LEN`, 4: `clk` cycles of stable input required by the glitch filter (only with `PWM_CAPTURE_FILTER_EN`).
- `clk` in 1: system clock. The block uses one clock.
- `rst` in 1: reset, synchronous and active-high.
- `enable` in 1: 1 enables measurement. 0 forces IDLE.
- `pwm_in` in 1: asynchronous PWM input.
- `period` out 32: last measured period, in µs.
- `dutty` out 32: last measured high time, in µs.
- `valid` out 1: one-cycle strobe when `period`/`dutty` update.
- `timeout` out 1: level. No edge for `TIMEOUT_US`.
- `stuck_level` out 1: synchronized input level at the moment `timeout` asserted.

## Operation
- Input path: 2-FF synchronizer, then the optional filter, then the edge detector (one registered prev sample). `rise`/`fall` are single-cycle pulses.
- Tick: a counter of `CLK_FREQ_HZ/1_000_000` cycles. `tick` is high for one `clk` cycle per µs. The tick counter free-runs; it is cleared only by `rst`.
- Measurement counter `cnt` (32 bit):
  - Cleared to 0 on the cycle a `rise` is accepted.
  - Otherwise increments on `tick`.
  - Saturates at 0xFFFF_FFFF.
  - If an edge and a tick occur in the same cycle, the edge action wins and that tick is not counted.
- FSM states: IDLE, WAIT_RISE, HIGH, LOW.
  - IDLE: `cnt` is held at 0. When `enable`=1, go to WAIT_RISE.
  - WAIT_RISE: ignore `fall`. On `rise`, clear `cnt` and go to HIGH.
  - HIGH: on `fall`, latch `dutty_tmp` = `cnt` and go to LOW.
  - LOW: on `rise`:
    - `period` <= `cnt`, `dutty` <= `dutty_tmp`, `valid` <= 1.
    - Clear `cnt` and go to HIGH. Back-to-back cycles are measured without gaps.
  - Any state except IDLE: when `cnt` reaches `TIMEOUT_US` with no edge, set `timeout`=1, latch `stuck_level`, and go to WAIT_RISE. `period`/`dutty` hold their last values.
  - `timeout` clears on the next accepted `rise`.
  - `enable`=0 in any state: go to IDLE next cycle and discard any partial measurement. `period`, `dutty`, `timeout` and `stuck_level` hold their values.
- The first `valid` after enable or timeout needs two rising edges.

## Timing
- Reset values: `period`=0, `dutty`=0, `valid`=0, `timeout`=0, `stuck_level`=0, FSM=IDLE, all counters 0, synchronizer flops 0.
- Reset applied mid-measurement returns everything to the reset values on the next edge. No `valid` is emitted.
- Latency from a `pwm_in` edge to the corresponding `rise`/`fall`: 3 `clk` without the filter, 3+`FILTER_LEN` with it.
- `valid` asserts 1 cycle after the `rise` pulse.
- `period` and `dutty` update on the same edge as `valid` and stay stable until the next `valid`.
- Resolution: ±1 µs on each measurement. Both fields use the same reference, so the systematic offset cancels in `period − dutty`.
- An input high or low time shorter than 3 `clk` (or `FILTER_LEN` with the filter) is not guaranteed to be seen.

## Configuration
- `PWM_CAPTURE_FILTER_EN` defined:
  - A glitch filter sits between the synchronizer and the edge detector.
  - The filtered level changes only after the synchronized input has held the new value for `FILTER_LEN` consecutive cycles.
  - Shorter pulses are dropped entirely.
- Not defined: the synchronizer output feeds the edge detector directly, and `FILTER_LEN` is unused.

## Test plan
Benches use `CLK_FREQ_HZ`=10_000_000 (10 `clk` per µs).
- Nominal: stimulus is the `pwm` generator at period 1000 µs, dutty 250 µs, with `enable`=1. Required: the second and every later `valid` report `period`∈[999,1001] and `dutty`∈[249,251]; `timeout` stays 0.
- Stuck input: with `TIMEOUT_US`=500, hold `pwm_in`=1 after one rise. Required: `timeout`=1 and `stuck_level`=1 within 501 µs; no `valid`; a later rise clears `timeout`.
- Enable drop: deassert `enable` 100 µs into HIGH, then reassert. Required: no `valid` for the aborted cycle; the old `period`/`dutty` are held; the next full cycle measures correctly.
- Reset mid-LOW: assert `rst` for 1 cycle. Required: all outputs are 0 the next cycle and the FSM is in IDLE.
- Glitch (with `PWM_CAPTURE_FILTER_EN`, `FILTER_LEN`=4): inject a 2-cycle low glitch inside the high phase of a 200/50 µs waveform. Required: `dutty`∈[49,51]. Without the macro, the same stimulus gives a short `dutty` and is recorded as expected.
- Back-to-back: change the waveform from 100/30 µs to 300/200 µs between cycles. Required: consecutive `valid`s report each pair ±1 µs, with no extra `valid` during the transition.

Source files
------------

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: control inputs and measurement results of pwm_capture.
//   enable      : 1 runs the measurement, 0 holds the block idle
//   pwm_in      : asynchronous PWM input
//   period      : last measured period in microseconds
//   dutty       : last measured high time in microseconds
//   valid       : one-cycle strobe when period/dutty update
//   timeout     : level, no qualifying edge for TIMEOUT_US
//   stuck_level : synchronized input level when timeout asserted
interface pwm_capture_if;
   logic        enable;
   logic        pwm_in;
   logic [31:0] period;
   logic [31:0] dutty;
   logic        valid;
   logic        timeout;
   logic        stuck_level;

   modport master (
      output enable, pwm_in,
      input  period, dutty, valid, timeout, stuck_level
   );

   modport slave (
      input  enable, pwm_in,
      output period, dutty, valid, timeout, stuck_level
   );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input
// in microseconds, publishing one result per complete input cycle.
// Ports:
//   clk  : system clock (CLK_FREQ_HZ, integer multiple of 1 MHz, >= 2 MHz)
//   rst  : synchronous active-high reset
//   bus  : pwm_capture_if.slave (enable, pwm_in in; period, dutty, valid,
//          timeout, stuck_level out, all outputs registered)
// Optional feature: define PWM_CAPTURE_FILTER_EN to insert a glitch filter
// of FILTER_LEN stable cycles between the synchronizer and edge detector.
module pwm_capture #(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned TIMEOUT_US  = 1_000_000,
   parameter int unsigned FILTER_LEN  = 4
) (
   input logic          clk,
   input logic          rst,
   pwm_capture_if.slave bus
);

   localparam int unsigned CW  = 32;
   localparam int unsigned DIV = CLK_FREQ_HZ / 1_000_000;
   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] TO_PRE    = CW'(TIMEOUT_US - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RISE = 2'd1,
      HIGH      = 2'd2,
      LOW       = 2'd3
   } state_t;

   // Input synchronizer and edge detector history
   logic sync1_q, sync2_q, prev_q;
   logic lvl_c, rise_c, fall_c, edge_c;

`ifdef PWM_CAPTURE_FILTER_EN
   // Glitch filter: follow sync2 only after it held a new value FILTER_LEN cycles
   logic          filt_q, filt_d;
   logic [CW-1:0] fcnt_q, fcnt_d;

   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (sync2_q != filt_q) begin
         if (fcnt_q == CW'(FILTER_LEN - 1)) begin
            filt_d = sync2_q;
         end else begin
            fcnt_d = fcnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= 1'b0;
         fcnt_q <= '0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign lvl_c = filt_q;
`else
   logic unused_filter_len_c;
   assign unused_filter_len_c = ^CW'(FILTER_LEN);
   assign lvl_c = sync2_q;
`endif

   assign rise_c = lvl_c & ~prev_q;
   assign fall_c = ~lvl_c & prev_q;
   assign edge_c = rise_c | fall_c;

   // Free-running microsecond tick
   logic [CW-1:0] tcnt_q, tcnt_d;
   logic          tick_c;

   assign tick_c = (tcnt_q == TICK_LAST);
   assign tcnt_d = tick_c ? '0 : tcnt_q + CW'(1);

   // Measurement state
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] dtmp_q, dtmp_d;
   logic [CW-1:0] period_q, period_d;
   logic [CW-1:0] dutty_q, dutty_d;
   logic          valid_q, valid_d;
   logic          timeout_q, timeout_d;
   logic          stuck_q, stuck_d;

   // Next-state and output logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dtmp_d    = dtmp_q;
      period_d  = period_q;
      dutty_d   = dutty_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
      stuck_d   = stuck_q;

      if (!bus.enable) begin
         // Partial measurement is dropped; published results are kept
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         // Edge cycles swallow a coincident tick
         if (state_q != IDLE && !edge_c && tick_c && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
         end

         case (state_q)
            IDLE: begin
               cnt_d   = '0;
               state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
               if (rise_c) begin
                  cnt_d     = '0;
                  timeout_d = 1'b0;
                  state_d   = HIGH;
               end
            end
            HIGH: begin
               if (fall_c) begin
                  dtmp_d  = cnt_q;
                  state_d = LOW;
               end
            end
            LOW: begin
               if (rise_c) begin
                  period_d  = cnt_q;
                  dutty_d   = dtmp_q;
                  valid_d   = 1'b1;
                  cnt_d     = '0;
                  timeout_d = 1'b0;
                  state_d   = HIGH;
               end
            end
            default: state_d = IDLE;
         endcase

         // Fires once, on the tick that brings cnt to TIMEOUT_US
         if (state_q != IDLE && !edge_c && tick_c && cnt_q == TO_PRE) begin
            timeout_d = 1'b1;
            stuck_d   = lvl_c;
            state_d   = WAIT_RISE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         prev_q    <= 1'b0;
         tcnt_q    <= '0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         dtmp_q    <= '0;
         period_q  <= '0;
         dutty_q   <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         stuck_q   <= 1'b0;
      end else begin
         sync1_q   <= bus.pwm_in;
         sync2_q   <= sync1_q;
         prev_q    <= lvl_c;
         tcnt_q    <= tcnt_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dtmp_q    <= dtmp_d;
         period_q  <= period_d;
         dutty_q   <= dutty_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         stuck_q   <= stuck_d;
      end
   end

   assign bus.period      = period_q;
   assign bus.dutty       = dutty_q;
   assign bus.valid       = valid_q;
   assign bus.timeout     = timeout_q;
   assign bus.stuck_level = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture at 10 MHz (10 clk per us).
// dut_a (TIMEOUT_US=2000) covers measurement scenarios; dut_b (TIMEOUT_US=500)
// covers the stuck-input timeout.
`timescale 1ns/1ps
module tb_pwm_capture;

   typedef struct {
      longint pmin;
      longint pmax;
      longint dmin;
      longint dmax;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #50 clk = ~clk;

   pwm_capture_if bus_a ();
   pwm_capture_if bus_b ();

   pwm_capture #(
      .CLK_FREQ_HZ(10_000_000),
      .TIMEOUT_US (2000),
      .FILTER_LEN (4)
   ) dut_a (
      .clk(clk),
      .rst(rst),
      .bus(bus_a)
   );

   pwm_capture #(
      .CLK_FREQ_HZ(10_000_000),
      .TIMEOUT_US (500),
      .FILTER_LEN (4)
   ) dut_b (
      .clk(clk),
      .rst(rst),
      .bus(bus_b)
   );

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   task automatic check_rng(input string name, input longint act,
                            input longint lo, input longint hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d, want [%0d,%0d] at %0t", name, act, lo, hi, $time);
      end
   endtask

   task automatic push_exp(input longint pmin, input longint pmax,
                           input longint dmin, input longint dmax);
      exp_t e;
      e.pmin = pmin; e.pmax = pmax; e.dmin = dmin; e.dmax = dmax;
      exp_q.push_back(e);
   endtask

   task automatic wait_us(input int n);
      #(n * 1000);
   endtask

   // One input cycle on dut_a; its result appears at the next rise
   task automatic cycle(input int hi_us, input int lo_us);
      push_exp(hi_us + lo_us - 1, hi_us + lo_us + 1, hi_us - 1, hi_us + 1);
      bus_a.pwm_in = 1'b1;
      wait_us(hi_us);
      bus_a.pwm_in = 1'b0;
      wait_us(lo_us);
   endtask

   task automatic start_run();
      @(negedge clk);
      bus_a.pwm_in = 1'b0;
      bus_a.enable = 1'b1;
      wait_us(5);
   endtask

   // Closing rise publishes the last cycle, then the block is disabled
   task automatic close_run();
      bus_a.pwm_in = 1'b1;
      wait_us(10);
      bus_a.enable = 1'b0;
      wait_us(1);
      bus_a.pwm_in = 1'b0;
      wait_us(5);
   endtask

   // Monitor: pops one expectation for every valid strobe
   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus_a.valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid_a: got valid=1 period=%0d dutty=%0d, want no valid at %0t",
                     bus_a.period, bus_a.dutty, $time);
         end else begin
            e = exp_q.pop_front();
            check_rng("period", longint'(bus_a.period), e.pmin, e.pmax);
            check_rng("dutty", longint'(bus_a.dutty), e.dmin, e.dmax);
            check_rng("timeout_at_valid", longint'(bus_a.timeout), 0, 0);
         end
      end
      if (bus_b.valid) begin
         total++;
         bad++;
         $display("FAIL unexpected_valid_b: got valid=1, want no valid at %0t", $time);
      end
   end

   initial begin : stim
      int n;
      rst          = 1'b1;
      bus_a.enable = 1'b0;
      bus_a.pwm_in = 1'b0;
      bus_b.enable = 1'b0;
      bus_b.pwm_in = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check_rng("rst_period_a", longint'(bus_a.period), 0, 0);
      check_rng("rst_dutty_a", longint'(bus_a.dutty), 0, 0);
      check_rng("rst_valid_a", longint'(bus_a.valid), 0, 0);
      check_rng("rst_timeout_a", longint'(bus_a.timeout), 0, 0);
      check_rng("rst_stuck_a", longint'(bus_a.stuck_level), 0, 0);
      check_rng("rst_timeout_b", longint'(bus_b.timeout), 0, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Nominal 1000/250
      start_run();
      cycle(250, 750);
      cycle(250, 750);
      close_run();
      check_rng("nominal_timeout", longint'(bus_a.timeout), 0, 0);

      // Back-to-back waveform change 100/30 -> 300/200
      start_run();
      cycle(30, 70);
      cycle(30, 70);
      cycle(30, 70);
      cycle(200, 100);
      cycle(200, 100);
      close_run();

      // Enable drop 100 us into HIGH
      start_run();
      cycle(200, 100);
      bus_a.pwm_in = 1'b1;
      wait_us(100);
      bus_a.enable = 1'b0;
      wait_us(2);
      check_rng("held_period", longint'(bus_a.period), 299, 301);
      check_rng("held_dutty", longint'(bus_a.dutty), 199, 201);
      bus_a.enable = 1'b1;
      wait_us(98);
      bus_a.pwm_in = 1'b0;
      wait_us(100);
      cycle(200, 100);
      close_run();

      // Glitch: 2-cycle low pulse 20 us into a 50 us high phase of 200 us
      start_run();
`ifdef PWM_CAPTURE_FILTER_EN
      push_exp(199, 201, 49, 51);
`else
      push_exp(19, 21, 19, 21);
      push_exp(178, 181, 28, 31);
`endif
      bus_a.pwm_in = 1'b1;
      wait_us(20);
      bus_a.pwm_in = 1'b0;
      #200;
      bus_a.pwm_in = 1'b1;
      #29800;
      bus_a.pwm_in = 1'b0;
      wait_us(150);
      cycle(50, 150);
      close_run();

      // Reset in the middle of LOW
      start_run();
      bus_a.pwm_in = 1'b1;
      wait_us(30);
      bus_a.pwm_in = 1'b0;
      wait_us(20);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_rng("midrst_period", longint'(bus_a.period), 0, 0);
      check_rng("midrst_dutty", longint'(bus_a.dutty), 0, 0);
      check_rng("midrst_valid", longint'(bus_a.valid), 0, 0);
      check_rng("midrst_timeout", longint'(bus_a.timeout), 0, 0);
      check_rng("midrst_stuck", longint'(bus_a.stuck_level), 0, 0);
      check_rng("midrst_state_idle", longint'(dut_a.state_q), 0, 0);
      rst = 1'b0;
      bus_a.enable = 1'b0;
      wait_us(5);

      // Stuck-high input on dut_b
      @(negedge clk);
      bus_b.enable = 1'b1;
      wait_us(5);
      bus_b.pwm_in = 1'b1;
      n = 0;
      while (n < 5015 && !bus_b.timeout) begin
         @(negedge clk);
         n++;
      end
      check_rng("stuck_timeout", longint'(bus_b.timeout), 1, 1);
      check_rng("stuck_timeout_cycles", longint'(n), 4980, 5015);
      check_rng("stuck_level", longint'(bus_b.stuck_level), 1, 1);
      bus_b.pwm_in = 1'b0;
      wait_us(10);
      check_rng("stuck_timeout_held", longint'(bus_b.timeout), 1, 1);
      bus_b.pwm_in = 1'b1;
      n = 0;
      while (n < 20 && bus_b.timeout) begin
         @(negedge clk);
         n++;
      end
      check_rng("timeout_clear", longint'(bus_b.timeout), 0, 0);
      bus_b.enable = 1'b0;
      bus_b.pwm_in = 1'b0;
      wait_us(5);

      check_rng("pending_results", longint'(exp_q.size()), 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
